// File: rtl/mips_cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_sequencer_if
//  Description : Bundle of the signals between the CPU sequencer and its
//                surroundings (instruction fields, stall inputs, next-PC,
//                and the state/status outputs).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    opcode       6   IR[31:26], valid from DECODE onward
//    fncode       6   IR[5:0]
//    regimm       5   IR[20:16]
//    waitrequest  1   memory bus stall
//    muldiv_busy  1   HI/LO unit still computing
//    pc_next      32  value the PC register takes at the next edge
//    state        3   0=HALTED 1=FETCH 2=DECODE 3=EXEC1 4=EXEC2
//    active       1   high unless HALTED
//    illegal      1   sticky: halted on an unsupported instruction
//    instr_count  COUNT_WIDTH retired-instruction count
//  Modports: master (core side driving the sequencer), slave (sequencer)
// ============================================================================
interface mips_cpu_sequencer_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [5:0]             opcode;
  logic [5:0]             fncode;
  logic [4:0]             regimm;
  logic                   waitrequest;
  logic                   muldiv_busy;
  logic [31:0]            pc_next;
  logic [2:0]             state;
  logic                   active;
  logic                   illegal;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    output opcode, fncode, regimm, waitrequest, muldiv_busy, pc_next,
    input  state, active, illegal, instr_count
  );

  modport slave (
    input  opcode, fncode, regimm, waitrequest, muldiv_busy, pc_next,
    output state, active, illegal, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_sequencer
//  Description : Multicycle state sequencer for the CPU core. Classifies each
//                fetched instruction (one-exec, two-exec, illegal), stalls on
//                waitrequest / muldiv_busy, halts on HALT_ADDR or an illegal
//                instruction, and counts retired instructions.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   core clock, rising edge
//    reset_n  in   synchronous active-low reset
//    bus      slave modport of mips_cpu_sequencer_if (instruction fields,
//             stalls, pc_next in; state, active, illegal, instr_count out)
// ============================================================================
module mips_cpu_sequencer #(
  parameter int          COUNT_WIDTH = 32,
  parameter logic [31:0] HALT_ADDR   = 32'h0000_0000
) (
  input  wire                   clk,
  input  wire                   reset_n,
  mips_cpu_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_HALTED = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_ONE = 2'd0,
    CLS_TWO = 2'd1,
    CLS_ILL = 2'd2
  } cls_t;

  localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_nxt;
  cls_t                   r_class;
  logic                   r_is_store;
  logic                   r_is_muldiv;
  logic                   r_is_link;
  logic                   r_illegal;
  logic [COUNT_WIDTH-1:0] r_count;

  cls_t                   w_class;
  logic                   w_is_store;
  logic                   w_is_muldiv;
  logic                   w_is_link;
  logic                   w_retire;
  logic                   w_illegal_set;

  // --------------------------------------------------------------------------
  // Instruction classification (live decode; captured on DECODE -> EXEC1)
  // --------------------------------------------------------------------------
  always_comb begin
    w_class     = CLS_ILL;
    w_is_store  = 1'b0;
    w_is_muldiv = 1'b0;
    w_is_link   = 1'b0;
    case (bus.opcode)
      6'h00: begin
        case (bus.fncode)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
          6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B:
            w_class = CLS_ONE;
          // MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU wait on the HI/LO unit
          6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
            w_class     = CLS_ONE;
            w_is_muldiv = 1'b1;
          end
          default: w_class = CLS_ILL;
        endcase
      end
      6'h01: begin
        case (bus.regimm)
          5'h00, 5'h01: w_class = CLS_ONE;
          // BLTZAL/BGEZAL take a second cycle for the link write
          5'h10, 5'h11: begin
            w_class   = CLS_TWO;
            w_is_link = 1'b1;
          end
          default: w_class = CLS_ILL;
        endcase
      end
      6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
        w_class = CLS_ONE;
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26:
        w_class = CLS_TWO;
      6'h28, 6'h29, 6'h2B: begin
        w_class    = CLS_ONE;
        w_is_store = 1'b1;
      end
      default: w_class = CLS_ILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_retire      = 1'b0;
    w_illegal_set = 1'b0;
    case (r_state)
      S_HALTED: w_state_nxt = S_HALTED;
      S_FETCH: begin
        if (!bus.waitrequest) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_class == CLS_ILL) begin
          w_state_nxt   = S_HALTED;
          w_illegal_set = 1'b1;
        end else begin
          w_state_nxt = S_EXEC1;
        end
      end
      S_EXEC1: begin
        case (r_class)
          CLS_TWO: begin
            // link branches never touch memory, so they ignore waitrequest
            if (r_is_link || !bus.waitrequest) begin
              w_state_nxt = S_EXEC2;
            end
          end
          CLS_ONE: begin
            if (!((r_is_store && bus.waitrequest) ||
                  (r_is_muldiv && bus.muldiv_busy))) begin
              w_retire = 1'b1;
            end
          end
          default: w_state_nxt = S_FETCH;
        endcase
      end
      S_EXEC2: w_retire = 1'b1;
      default: w_state_nxt = S_FETCH;
    endcase
    // Halt address is only looked at on the retiring edge
    if (w_retire) begin
      w_state_nxt = (bus.pc_next == HALT_ADDR) ? S_HALTED : S_FETCH;
    end
  end

  // --------------------------------------------------------------------------
  // State, class and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_FETCH;
      r_class     <= CLS_ONE;
      r_is_store  <= 1'b0;
      r_is_muldiv <= 1'b0;
      r_is_link   <= 1'b0;
      r_illegal   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE && w_class != CLS_ILL) begin
        r_class     <= w_class;
        r_is_store  <= w_is_store;
        r_is_muldiv <= w_is_muldiv;
        r_is_link   <= w_is_link;
      end
      if (w_illegal_set) begin
        r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_count <= r_count + c_COUNT_ONE;
      end
    end
  end

  assign bus.state       = r_state;
  assign bus.active      = (r_state != S_HALTED);
  assign bus.illegal     = r_illegal;
  assign bus.instr_count = r_count;

endmodule
`default_nettype wire
